// File: rtl/flash_kickstart_pkg.sv
`default_nettype none
// ============================================================================
// Package : flash_kickstart_pkg
// Brief   : Shared decode bases and AUTOCONFIG register map for the relocator.
// Rev     : 1.0  initial release
// ============================================================================
package flash_kickstart_pkg;

    // AUTOCONFIG register offsets, indexed by A[7:1]
    localparam logic [6:0] AC_REG_TYPE    = 7'h00;
    localparam logic [6:0] AC_REG_SIZE    = 7'h01;
    localparam logic [6:0] AC_REG_PROD_HI = 7'h02;
    localparam logic [6:0] AC_REG_PROD_LO = 7'h03;
    localparam logic [6:0] AC_REG_FLAGS   = 7'h04;
    localparam logic [6:0] AC_REG_MANUF_0 = 7'h08;
    localparam logic [6:0] AC_REG_MANUF_1 = 7'h09;
    localparam logic [6:0] AC_REG_MANUF_2 = 7'h0A;
    localparam logic [6:0] AC_REG_MANUF_3 = 7'h0B;
    localparam logic [6:0] AC_REG_BASE_HI = 7'h24;
    localparam logic [6:0] AC_REG_BASE_LO = 7'h25;
    localparam logic [6:0] AC_REG_SHUTUP  = 7'h26;

    localparam logic [3:0] AC_ER_TYPE   = 4'hC;
    localparam logic [3:0] AC_FLAGS_NIB = 4'h7;

    // A[23:16] decode bases
    localparam logic [7:0] KS_BASE      = 8'hF8;
    localparam logic [7:0] AC_BASE      = 8'hE8;
    localparam logic [7:0] CHIPREG_BASE = 8'hDF;
    localparam logic [7:0] VEC_BASE     = 8'h00;

    function automatic logic [3:0] ac_size_code(input int num_banks);
        return (num_banks == 4) ? 4'h6 : 4'h5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kickstart_mode_selector.sv
`default_nettype none
// ============================================================================
// Module : kickstart_mode_selector
// Brief  : Counts how long /RESET is held and steps the image/programming mode.
// Rev    : 1.0  initial release
// ============================================================================
module kickstart_mode_selector #(
    parameter int NUM_BANKS   = 2,
    parameter int HOLD_CYCLES = 7093790,
    parameter int SEL_BITS    = $clog2(NUM_BANKS + 1)
) (
    input  logic                MB_CLK,
    input  logic                RESET,
    output logic [SEL_BITS-1:0] sel,
    output logic                prog_mode
);

    localparam int                    HCNT_BITS = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_BITS-1:0]  HCNT_LAST = HCNT_BITS'(HOLD_CYCLES - 1);
    localparam logic [SEL_BITS-1:0]   SEL_PROG  = SEL_BITS'(NUM_BANKS);

    // Deliberately outside RESET: the selection must survive the reset that chose it.
    logic [HCNT_BITS-1:0] hcnt_q = '0;
    logic [SEL_BITS-1:0]  sel_q  = '0;
    logic [HCNT_BITS-1:0] hcnt_d;
    logic [SEL_BITS-1:0]  sel_d;

    always_comb begin
        hcnt_d = '0;
        sel_d  = sel_q;
        if (!RESET) begin
            if (hcnt_q == HCNT_LAST) begin
                sel_d = (sel_q == SEL_PROG) ? '0 : sel_q + SEL_BITS'(1);
            end else begin
                hcnt_d = hcnt_q + HCNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge MB_CLK) begin
        hcnt_q <= hcnt_d;
        sel_q  <= sel_d;
    end

    assign sel       = sel_q;
    assign prog_mode = (sel_q == SEL_PROG);

endmodule
`default_nettype wire

// File: rtl/flash_kickstart_banked.sv
`default_nettype none
// ============================================================================
// Module : flash_kickstart_banked
// Brief  : Multi-bank flash Kickstart relocator with AUTOCONFIG reflash mode.
// Rev    : 1.0  initial release
// ============================================================================
module flash_kickstart_banked
    import flash_kickstart_pkg::*;
#(
    parameter int          NUM_BANKS   = 2,
    parameter int          BANK_BITS   = $clog2(NUM_BANKS),
    parameter int          HOLD_CYCLES = 7093790,
    parameter int          DTACK_WAIT  = 2,
    parameter logic [7:0]  AC_PRODUCT  = 8'h10,
    parameter logic [15:0] AC_MANUF    = 16'h07DB
) (
    input  logic                 MB_CLK,
    input  logic                 RESET,
    input  logic                 CPU_AS,
    output logic                 MB_AS,
    output wire                  MB_DTACK,
    input  logic                 RW,
    input  logic                 UDS,
    input  logic                 LDS,
    input  logic [7:0]           ADDRESS_HIGH,
    input  logic [6:0]           ADDRESS_LOW,
    inout  wire  [3:0]           DATA,
    output logic [1:0]           FLASH_RD,
    output logic [1:0]           FLASH_WR,
    output logic [BANK_BITS-1:0] FLASH_BANK,
    output logic                 PROG_MODE
);

    localparam int                   SEL_BITS  = $clog2(NUM_BANKS + 1);
    localparam int                   WIN_LSB   = 3 + BANK_BITS;
    localparam logic [7:0]           WIN_MASK  = 8'hFF << WIN_LSB;
    localparam int                   WCNT_BITS = $clog2(DTACK_WAIT + 2);
    localparam logic [WCNT_BITS-1:0] WCNT_MAX  = WCNT_BITS'(DTACK_WAIT);

    logic [SEL_BITS-1:0] w_sel;
    logic                w_prog;

    kickstart_mode_selector #(
        .NUM_BANKS   (NUM_BANKS),
        .HOLD_CYCLES (HOLD_CYCLES),
        .SEL_BITS    (SEL_BITS)
    ) u_mode_selector (
        .MB_CLK    (MB_CLK),
        .RESET     (RESET),
        .sel       (w_sel),
        .prog_mode (w_prog)
    );

    logic                 ovl_q, ovl_d, wpend_q, wpend_d;
    logic                 configured_q, configured_d, shutup_q, shutup_d;
    logic                 acw_done_q, acw_done_d;
    logic [7:0]           base_q, base_d;
    logic [WCNT_BITS-1:0] wcnt_q, wcnt_d;

    logic w_cycle, w_strobe, w_ks, w_rst, w_ac, w_fl, w_internal;
    logic [3:0] w_ac_nib;

    // Qualifying on RESET makes an asserted reset abort the cycle combinationally.
    assign w_cycle    = RESET & ~CPU_AS;
    assign w_strobe   = ~(UDS & LDS);
    assign w_ks       = w_cycle && (ADDRESS_HIGH[7:3] == KS_BASE[7:3]);
    assign w_rst      = w_cycle && (ADDRESS_HIGH == VEC_BASE) && !ovl_q;
    assign w_ac       = w_cycle && (ADDRESS_HIGH == AC_BASE) && w_prog && !configured_q && !shutup_q;
    assign w_fl       = w_cycle && w_prog && configured_q &&
                        ((ADDRESS_HIGH & WIN_MASK) == (base_q & WIN_MASK));
    assign w_internal = ((w_ks | w_rst) & ~w_prog) | w_ac;

    always_comb begin
        ovl_d        = ovl_q;
        wpend_d      = wpend_q;
        configured_d = configured_q;
        shutup_d     = shutup_q;
        base_d       = base_q;
        acw_done_d   = CPU_AS ? 1'b0 : acw_done_q;
        wcnt_d       = CPU_AS ? '0 : (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_BITS'(1);
        if (!CPU_AS && !RW && w_strobe && (ADDRESS_HIGH == CHIPREG_BASE) && !w_prog) begin
            wpend_d = 1'b1;
        end
        if (CPU_AS && wpend_q) begin
            ovl_d = 1'b1;
        end
        if (w_ac && !RW && w_strobe && !acw_done_q) begin
            acw_done_d = 1'b1;
            case (ADDRESS_LOW)
                AC_REG_BASE_LO: base_d[3:0] = DATA;
                AC_REG_BASE_HI: begin
                    base_d[7:4]  = DATA;
                    configured_d = 1'b1;
                end
                AC_REG_SHUTUP:  shutup_d = 1'b1;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            ovl_q        <= 1'b0;
            wpend_q      <= 1'b0;
            configured_q <= 1'b0;
            shutup_q     <= 1'b0;
            acw_done_q   <= 1'b0;
            base_q       <= '0;
            wcnt_q       <= '0;
        end else begin
            ovl_q        <= ovl_d;
            wpend_q      <= wpend_d;
            configured_q <= configured_d;
            shutup_q     <= shutup_d;
            acw_done_q   <= acw_done_d;
            base_q       <= base_d;
            wcnt_q       <= wcnt_d;
        end
    end

    always_comb begin
        w_ac_nib = 4'hF;
        case (ADDRESS_LOW)
            AC_REG_TYPE:    w_ac_nib = AC_ER_TYPE;
            AC_REG_SIZE:    w_ac_nib = ac_size_code(NUM_BANKS);
            AC_REG_PROD_HI: w_ac_nib = ~AC_PRODUCT[7:4];
            AC_REG_PROD_LO: w_ac_nib = ~AC_PRODUCT[3:0];
            AC_REG_FLAGS:   w_ac_nib = AC_FLAGS_NIB;
            AC_REG_MANUF_0: w_ac_nib = ~AC_MANUF[15:12];
            AC_REG_MANUF_1: w_ac_nib = ~AC_MANUF[11:8];
            AC_REG_MANUF_2: w_ac_nib = ~AC_MANUF[7:4];
            AC_REG_MANUF_3: w_ac_nib = ~AC_MANUF[3:0];
            default:        ;
        endcase
    end

    assign DATA     = (w_ac && RW && w_strobe) ? w_ac_nib : 4'bzzzz;
    assign MB_DTACK = (w_internal && (wcnt_q == WCNT_MAX)) ? 1'b0 : 1'bz;

    always_comb begin
        MB_AS      = w_internal ? 1'b1 : CPU_AS;
        FLASH_RD   = (RW && ((w_internal && !w_ac) || w_fl)) ? {UDS, LDS} : 2'b11;
        FLASH_WR   = (!RW && w_fl) ? {UDS, LDS} : 2'b11;
        FLASH_BANK = w_prog ? ADDRESS_HIGH[WIN_LSB-1:3] : BANK_BITS'(w_sel);
        PROG_MODE  = w_prog;
    end

endmodule
`default_nettype wire
